et_seq: RTL and testbench

- Front/back-end sequencer for the e^x Taylor-series evaluation unit (control unit plus FP datapath).
- Accepts FP32 operands over a valid/ready stream and holds each operand on the unit's num input for the full evaluation window.
- Releases the unit's active-high reset for exactly one evaluation, captures the result when the unit signals done, and presents it on a valid/ready output stream.
- Uses a one-entry result register so a new evaluation can overlap a stalled output.

---
 rtl/et_seq.sv | 156 +++++++++++++++
 tb/tb_et_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/et_seq.sv
// Front/back-end sequencer for the e^x Taylor evaluation unit: feeds one FP32
// operand per evaluation, releases the unit's reset for that run, and buffers the result.
module et_seq #(
  parameter int TIMEOUT = 32,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] eu_num,
  output logic         eu_res,
  input  logic         eu_done,
  input  logic [W-1:0] eu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         busy
);

  // state    | meaning
  // IDLE     | unit held in reset, waiting for an operand
  // RUN      | unit evaluating; waiting for eu_done or timeout
  // WAIT_OUT | result ready but output slot full; unit keeps cycling until it frees
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, cnt_inc;
  logic           cnt_tc;
  logic [W-1:0]   eu_num_nxt;
  logic           eu_res_nxt;
  logic           out_valid_nxt;
  logic [W-1:0]   out_data_nxt;
  logic           out_err_nxt;
  logic           slot_free;
  logic           do_cap;
  logic           do_err;

  assign in_ready  = (state == IDLE) && res_n;
  assign busy      = (state != IDLE);
  assign slot_free = !out_valid || out_ready;
  assign cnt_tc    = (cnt == CNT_TC);
  assign cnt_inc   = cnt_tc ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    eu_num_nxt    = eu_num;
    eu_res_nxt    = eu_res;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_err_nxt   = out_err;
    do_cap        = 1'b0;
    do_err        = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          eu_num_nxt = in_data;
          eu_res_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        cnt_nxt = cnt_inc;
        // cnt==0 is the cycle the unit leaves reset; its strobe may still be stale
        if (eu_done && (cnt != '0)) begin
          if (slot_free) begin
            do_cap = 1'b1;
          end else begin
            state_nxt = WAIT_OUT;
            cnt_nxt   = '0;
          end
        end else if (cnt_tc) begin
          if (slot_free) begin
            do_err = 1'b1;
          end else begin
            state_nxt = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        cnt_nxt = cnt_inc;
        if (eu_done) begin
          if (slot_free) begin
            do_cap = 1'b1;
          end else begin
            cnt_nxt = '0;
          end
        end else if (cnt_tc && slot_free) begin
          do_err = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (out_valid && out_ready) begin
      out_valid_nxt = 1'b0;
    end

    if (do_cap) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = eu_result;
      out_err_nxt   = 1'b0;
    end else if (do_err) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = '0;
      out_err_nxt   = 1'b1;
    end

    if (do_cap || do_err) begin
      state_nxt  = IDLE;
      eu_res_nxt = 1'b1;
      cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt       <= '0;
      eu_num    <= '0;
      eu_res    <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      eu_num    <= eu_num_nxt;
      eu_res    <= eu_res_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_err   <= out_err_nxt;
    end
  end

endmodule

// File: tb/tb_et_seq.sv
// Bench for et_seq: a 13-state evaluation-unit stand-in, a cycle-count based
// reference model, directed scenarios and a randomized run.
module tb_et_seq;
  localparam int W       = 32;
  localparam int TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         res_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, eu_res, eu_done, out_valid, out_err, busy;
  logic [W-1:0] eu_num, eu_result, out_data;

  int checks = 0;
  int errors = 0;

  et_seq #(.TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .eu_num    (eu_num),
    .eu_res    (eu_res),
    .eu_done   (eu_done),
    .eu_result (eu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ex_of(input logic [31:0] x);
    if (x == 32'h3F800000) return 32'h402DF854;
    return {x[15:0], x[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  // Unit stand-in: reset to wrap, then 1..12 and strobe on 13, repeating every 13 cycles.
  int pos = 0;
  bit stale_en = 1'b0;
  bit nodone = 1'b0;
  always @(posedge clk) pos <= eu_res ? 0 : ((pos == 13) ? 1 : pos + 1);
  assign eu_done   = !nodone && ((pos == 13) || (stale_en && pos == 0 && !eu_res));
  assign eu_result = ex_of(eu_num);

  // Reference model: a run accepted at edge k captures at the first edge k+14+13m
  // with a free slot; with no strobe it errors at the first edge >= k+33 with a free slot.
  int           cyc = 0;
  bit           m_busy = 1'b0;
  int           m_k = 0;
  logic [31:0]  m_op = '0;
  bit           m_valid = 1'b0;
  logic [31:0]  m_data = '0;
  bit           m_err = 1'b0;

  always @(posedge clk or negedge res_n) begin : model
    int e, j;
    bit free, hit;
    if (!res_n) begin
      m_busy  <= 1'b0;
      m_op    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else begin
      e = cyc + 1;
      cyc <= e;
      free = !m_valid || out_ready;
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (m_busy) begin
        j = e - m_k;
        hit = !nodone && (j >= 14) && ((j - 14) % 13 == 0);
        if (hit && free) begin
          m_valid <= 1'b1; m_data <= ex_of(m_op); m_err <= 1'b0; m_busy <= 1'b0;
        end else if (nodone && (j >= TIMEOUT + 1) && free) begin
          m_valid <= 1'b1; m_data <= '0; m_err <= 1'b1; m_busy <= 1'b0;
        end
      end else if (in_valid) begin
        m_busy <= 1'b1; m_k <= e; m_op <= in_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!res_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_eu_res", eu_res, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_eu_num", eu_num, 0);
    end else begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("eu_res", eu_res, !m_busy);
      chk("eu_num", eu_num, m_op);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_err", out_err, m_err);
      end
    end
  end

  // Called at a negedge; returns at the negedge after accept edge k.
  task automatic send(input logic [31:0] op, output int k);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = op;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready stayed 0 for %0d cycles, expected 1", n);
      in_valid = 1'b0;
      k = cyc;
    end else begin
      k = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic at_edge(input int e);
    int n;
    n = e - cyc;
    if (n > 0) repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k, ka, kb, kc, lowcnt;
    #1 res_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_eu_res", eu_res, 1);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_data", out_data, 0);
    res_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // single op
    out_ready = 1'b1;
    send(32'h3F800000, k);
    lowcnt = 0;
    for (int i = 0; i <= 20; i++) begin
      if (!eu_res) lowcnt++;
      if (i == 13) chk("single_pre_valid", out_valid, 0);
      if (i == 14) begin
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 32'h402DF854);
        chk("single_err", out_err, 0);
      end
      @(negedge clk);
    end
    chk("single_eu_res_low_cycles", lowcnt, 14);

    // timeout
    nodone = 1'b1;
    send(32'h40000000, k);
    for (int i = 0; i <= 34; i++) begin
      if (i == 32) chk("timeout_pre_valid", out_valid, 0);
      if (i == 33) begin
        chk("timeout_valid", out_valid, 1);
        chk("timeout_err", out_err, 1);
        chk("timeout_data", out_data, 0);
        chk("timeout_eu_res", eu_res, 1);
        chk("timeout_in_ready", in_ready, 1);
      end
      @(negedge clk);
    end
    nodone = 1'b0;

    // stale strobe right after accept
    stale_en = 1'b1;
    send(32'h3F000000, k);
    for (int i = 0; i <= 15; i++) begin
      if (i == 1) begin
        chk("stale_busy", busy, 1);
        chk("stale_no_capture", out_valid, 0);
      end
      if (i == 14) begin
        chk("stale_valid", out_valid, 1);
        chk("stale_data", out_data, 32'h5A5AFCC3);
      end
      @(negedge clk);
    end
    stale_en = 1'b0;

    // reset mid-run
    send(32'h3F800000, k);
    at_edge(k + 6);
    #2 res_n = 1'b0;
    #1;
    chk("midrst_eu_res", eu_res, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_eu_num", eu_num, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    send(32'hBF800000, k);
    at_edge(k + 14);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_data", out_data, 32'h5A5A7C43);
    at_edge(k + 16);

    // back-pressure
    out_ready = 1'b0;
    send(32'h11112222, ka);
    send(32'hC0490FDB, kb);
    chk("bp_second_accept_edge", kb - ka, 15);
    at_edge(kb + 15);
    chk("bp_wait_busy", busy, 1);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 32'h7878D2D2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_drained", out_valid, 0);
    at_edge(kb + 26);
    chk("bp_not_yet", out_valid, 0);
    at_edge(kb + 27);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_data, 32'h5581038A);
    chk("bp_idle", busy, 0);

    // simultaneous consume and capture
    send(32'h00000000, kc);
    at_edge(kc + 13);
    chk("sim_old_data", out_data, 32'h5581038A);
    out_ready = 1'b1;
    at_edge(kc + 14);
    chk("sim_valid", out_valid, 1);
    chk("sim_new_data", out_data, 32'h5A5AC3C3);

    // randomized run
    repeat (3000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      stale_en  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale_en  = 1'b0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
